fmap_stream_tx: RTL and testbench

- Transmitter side of the feature-map pixel stream consumed by the 5x5 conv feature-map blocks (data/valid interface, DATA_WIDTH-bit fixed-point pixels, raster order).
- Reads one IMG_W x IMG_H frame from a synchronous single-port buffer RAM and emits it as a valid-qualified stream.
- Inserts ROW_GAP idle cycles after each row, supports pause, and flags start-of-frame, end-of-line and frame completion.

---
 rtl/fmap_stream_tx_pkg.sv | 28 ++
 rtl/fmap_stream_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_fmap_stream_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_stream_tx_pkg.sv
// Shared definitions for the feature-map pixel stream transmitter:
// pixel format, sequencer states and frame geometry helper.
package fmap_stream_tx_pkg;

  // Pixel format shared with the 5x5 conv feature-map datapath (Q8.16).
  localparam int FMAP_DATA_WIDTH = 24;
  localparam int FMAP_INT_BITS   = 8;
  localparam int FMAP_FRAC_BITS  = 16;

  // Cycles spent in DRAIN after the last read strobe is on the bus: the
  // read data returns one cycle later and is registered one cycle after
  // that, so done can fire on the cycle after the last valid pixel.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } fmap_state_e;

  // Number of pixels in one frame.
  function automatic int unsigned fmap_frame_size(input int unsigned w,
                                                  input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/fmap_stream_tx.sv
// Feature-map stream transmitter: reads one IMG_W x IMG_H frame in raster
// order from a synchronous single-port buffer and emits it as a
// valid-qualified pixel stream with sof/eol markers, optional inter-row
// idle gaps, pause gating of reads and a done pulse at frame end.
module fmap_stream_tx
  import fmap_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = FMAP_DATA_WIDTH,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ROW_GAP    = 0,
  parameter int ADDR_WIDTH = $clog2(fmap_frame_size(IMG_W, IMG_H))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy,
  output logic                  done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ROW_GAP > 0) ? (ROW_GAP - 1) : 0);
  localparam bit               HAS_GAP  = (ROW_GAP > 0);

  // Sequencer and raster counters
  fmap_state_e            state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Read strobe stage (cycle t) and its markers
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                   rd_sof_q, rd_sof_d;
  logic                   rd_eol_q, rd_eol_d;

  // Data-return stage (cycle t+1), aligned with rd_data
  logic                   pv_q, pv_d;
  logic                   psof_q, psof_d;
  logic                   peol_q, peol_d;

  // Output stage (cycle t+2)
  logic                   valid_q, valid_d;
  logic                   sof_q, sof_d;
  logic                   eol_q, eol_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  // Position of the pixel considered for issue this cycle
  logic                   issue_s;
  logic [COL_W-1:0]       col_cur_s;
  logic [ROW_W-1:0]       row_cur_s;
  logic [ADDR_WIDTH-1:0]  addr_cur_s;

  // Next-state, read-issue decision and read-latency pipeline
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    gap_cnt_d   = gap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_sof_d    = 1'b0;
    rd_eol_d    = 1'b0;
    issue_s     = 1'b0;
    col_cur_s   = col_q;
    row_cur_s   = row_q;
    addr_cur_s  = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Counters restart from the frame origin; a paused start is
          // still accepted and simply waits in READ.
          state_d    = ST_READ;
          busy_d     = 1'b1;
          col_cur_s  = '0;
          row_cur_s  = '0;
          addr_cur_s = '0;
          col_d      = '0;
          row_d      = '0;
          addr_d     = '0;
          issue_s    = ~pause;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_READ: begin
        issue_s = ~pause;
      end
      ST_GAP: begin
        // The gap counter ignores pause; pause only gates read strobes.
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_READ;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = ST_IDLE;
          drain_cnt_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (issue_s) begin
      rd_en_d   = 1'b1;
      rd_addr_d = addr_cur_s;
      rd_sof_d  = (addr_cur_s == '0);
      rd_eol_d  = (col_cur_s == COL_LAST);
      if (col_cur_s == COL_LAST) begin
        col_d = '0;
        if (row_cur_s == ROW_LAST) begin
          // Frame fully issued; clearing addr keeps it inside the frame.
          state_d     = ST_DRAIN;
          row_d       = '0;
          addr_d      = '0;
          drain_cnt_d = '0;
        end else begin
          row_d     = row_cur_s + 1'b1;
          addr_d    = addr_cur_s + 1'b1;
          state_d   = HAS_GAP ? ST_GAP : ST_READ;
          gap_cnt_d = '0;
        end
      end else begin
        col_d  = col_cur_s + 1'b1;
        addr_d = addr_cur_s + 1'b1;
      end
    end else begin
      rd_en_d = 1'b0;
    end

    // Markers travel with the read through the RAM latency stage.
    pv_d    = rd_en_q;
    psof_d  = rd_sof_q;
    peol_d  = rd_eol_q;
    valid_d = pv_q;
    sof_d   = psof_q;
    eol_d   = peol_q;
    if (pv_q) begin
      data_d = rd_data;
    end else begin
      data_d = data_q;
    end
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      gap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_sof_q    <= 1'b0;
      rd_eol_q    <= 1'b0;
      pv_q        <= 1'b0;
      psof_q      <= 1'b0;
      peol_q      <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      gap_cnt_q   <= gap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_sof_q    <= rd_sof_d;
      rd_eol_q    <= rd_eol_d;
      pv_q        <= pv_d;
      psof_q      <= psof_d;
      peol_q      <= peol_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      data_q      <= data_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Self-checking bench for fmap_stream_tx (4x3 frames, ROW_GAP 0 and 2).
// The reference model derives each pixel's read cycle from the stream
// rules (start latency, pause gating, row gaps) and expects every output
// relative to those cycles.
module tb_fmap_stream_tx;

  localparam int DW = 24;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;

  logic          rd_en0, valid0, sof0, eol0, busy0, done0;
  logic [AW-1:0] rd_addr0;
  logic [DW-1:0] rd_data0 = '0, data0;
  logic          rd_en2, valid2, sof2, eol2, busy2, done2;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data2 = '0, data2;

  int checks = 0;
  int errors = 0;
  bit pause_tab [0:255];
  int exp_issue [0:N-1];

  always #5 clk = ~clk;

  fmap_stream_tx #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ROW_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .data_out(data0), .valid_out(valid0), .sof(sof0), .eol(eol0),
    .busy(busy0), .done(done0));

  fmap_stream_tx #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ROW_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .data_out(data2), .valid_out(valid2), .sof(sof2), .eol(eol2),
    .busy(busy2), .done(done2));

  // Buffer RAM models: word[a] = 0x100 + a, one-cycle read latency
  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= DW'(256) + DW'(rd_addr0);
    if (rd_en2) rd_data2 <= DW'(256) + DW'(rd_addr2);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic clear_pause();
    for (int i = 0; i < 256; i++) pause_tab[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      pause = 1'b0;
    end
  endtask

  // Runs one frame on the selected DUT: start in relative cycle 0, pause
  // from pause_tab, an optional extra start pulse in cycle extra_start.
  task automatic run_frame(input string name, input bit sel2, input int extra_start);
    int gap, c, prev, done_cyc, k, vk;
    bit seen;
    logic [DW-1:0] hold, e_data;
    logic o_rd, o_v, o_sof, o_eol, o_busy, o_done;
    logic e_rd, e_v, e_sof, e_eol, e_busy, e_done;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    gap  = sel2 ? 2 : 0;
    prev = 0;
    for (int i = 0; i < N; i++) begin
      c = (i == 0) ? 1 : prev + 1;
      if (i > 0 && (i % W) == 0 && c < prev + gap + 1) c = prev + gap + 1;
      while (c < 250 && pause_tab[c-1]) c++;
      exp_issue[i] = c;
      prev = c;
    end
    done_cyc = prev + 3;
    k = 0;
    vk = 0;
    seen = 1'b0;
    hold = '0;
    for (int r = 0; r <= done_cyc; r++) begin
      @(negedge clk);
      o_rd   = sel2 ? rd_en2   : rd_en0;
      o_addr = sel2 ? rd_addr2 : rd_addr0;
      o_data = sel2 ? data2    : data0;
      o_v    = sel2 ? valid2   : valid0;
      o_sof  = sel2 ? sof2     : sof0;
      o_eol  = sel2 ? eol2     : eol0;
      o_busy = sel2 ? busy2    : busy0;
      o_done = sel2 ? done2    : done0;
      e_rd   = (k < N) && (exp_issue[k] == r);
      e_v    = (vk < N) && (exp_issue[vk] + 2 == r);
      e_sof  = e_v && (vk == 0);
      e_eol  = e_v && ((vk % W) == W - 1);
      e_busy = (r >= 1) && (r <= done_cyc - 1);
      e_done = (r == done_cyc);
      e_data = DW'(256 + vk);

      checks++;
      if (o_rd !== e_rd) begin
        errors++;
        $display("FAIL %s rd_en cyc=%0d got=%b exp=%b", name, r, o_rd, e_rd);
      end
      if (e_rd) begin
        checks++;
        if (o_addr !== AW'(k)) begin
          errors++;
          $display("FAIL %s rd_addr cyc=%0d got=%0d exp=%0d", name, r, o_addr, k);
        end
      end
      checks++;
      if (o_v !== e_v) begin
        errors++;
        $display("FAIL %s valid_out cyc=%0d got=%b exp=%b", name, r, o_v, e_v);
      end
      checks++;
      if (o_sof !== e_sof) begin
        errors++;
        $display("FAIL %s sof cyc=%0d got=%b exp=%b", name, r, o_sof, e_sof);
      end
      checks++;
      if (o_eol !== e_eol) begin
        errors++;
        $display("FAIL %s eol cyc=%0d got=%b exp=%b", name, r, o_eol, e_eol);
      end
      checks++;
      if (o_busy !== e_busy) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, r, o_busy, e_busy);
      end
      checks++;
      if (o_done !== e_done) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", name, r, o_done, e_done);
      end
      if (e_v) begin
        checks++;
        if (o_data !== e_data) begin
          errors++;
          $display("FAIL %s data_out cyc=%0d got=%h exp=%h", name, r, o_data, e_data);
        end
        hold = e_data;
        seen = 1'b1;
      end else if (seen) begin
        checks++;
        if (o_data !== hold) begin
          errors++;
          $display("FAIL %s data_hold cyc=%0d got=%h exp=%h", name, r, o_data, hold);
        end
      end
      if (e_rd) k++;
      if (e_v) vk++;
      start = (r == 0) || (r == extra_start);
      pause = (r < 256) ? pause_tab[r] : 1'b0;
    end
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({rd_en0, rd_addr0, data0, valid0, sof0, eol0, busy0, done0} !== '0) begin
      errors++;
      $display("FAIL %s dut0 outputs got rd_en=%b addr=%0d data=%h v=%b sof=%b eol=%b busy=%b done=%b exp all 0",
               name, rd_en0, rd_addr0, data0, valid0, sof0, eol0, busy0, done0);
    end
    checks++;
    if ({rd_en2, rd_addr2, data2, valid2, sof2, eol2, busy2, done2} !== '0) begin
      errors++;
      $display("FAIL %s dut2 outputs got rd_en=%b addr=%0d data=%h v=%b sof=%b eol=%b busy=%b done=%b exp all 0",
               name, rd_en2, rd_addr2, data2, valid2, sof2, eol2, busy2, done2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_pause();
    run_frame("basic", 1'b0, -1);
  endtask

  task automatic test_pause();
    clear_pause();
    for (int i = 6; i <= 8; i++) pause_tab[i] = 1'b1;
    run_frame("pause", 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    clear_pause();
    run_frame("start_ignored", 1'b0, 9);
    run_frame("back_to_back", 1'b0, -1);
  endtask

  task automatic test_start_with_pause();
    clear_pause();
    for (int i = 0; i <= 3; i++) pause_tab[i] = 1'b1;
    run_frame("start_paused", 1'b0, -1);
  endtask

  task automatic test_row_gap();
    idle(40);
    clear_pause();
    run_frame("row_gap", 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    bit found;
    idle(40);
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en0 === 1'b1 && rd_addr0 === AW'(7)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid wait_addr7 got=timeout exp=rd_addr 7 issued");
    end
    #1 rst = 1'b0;
    #1 check_all_zero("reset_mid_async");
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    clear_pause();
    run_frame("after_reset", 1'b0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      idle(40);
      clear_pause();
      for (int i = 0; i < 60; i++) pause_tab[i] = ($urandom_range(0, 2) == 0);
      run_frame($sformatf("random%0d", it), (it % 2) == 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_back_to_back();
    test_start_with_pause();
    test_row_gap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
